// File: rtl/explode_sequencer.sv
// Game-over animation sequencer: steps an explosion / red flash / END-text index,
// holding each position for FRAME_TICKS cycles, then holds the END screen until restart.
module explode_sequencer #(
    parameter int unsigned FRAME_TICKS = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       collide,
    input  logic       restart,
    output logic [3:0] position,
    output logic       frame_strobe,
    output logic       busy,
    output logic       done
);

    localparam int unsigned      CNT_W    = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_TICKS - 1);
    localparam logic [3:0]       POS_LAST = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXPLODE = 2'd1,
        ST_FLASH   = 2'd2,
        ST_ENDSCR  = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_pos;
    logic             r_strobe;
    logic             r_busy;
    logic             r_done;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       w_pos_nxt;

    // Animation phase owning a given position index.
    function automatic state_t state_of(input logic [3:0] pos);
        if (pos == 4'd0) begin
            return ST_IDLE;
        end else if (pos <= 4'd4) begin
            return ST_EXPLODE;
        end else if (pos == 4'd5) begin
            return ST_FLASH;
        end else begin
            return ST_ENDSCR;
        end
    endfunction

    // Next state / counter / position; restart overrides any pending advance.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pos_nxt   = r_pos;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (restart) begin
                    w_pos_nxt = 4'd0;
                end else if (collide) begin
                    w_state_nxt = ST_EXPLODE;
                    w_pos_nxt   = 4'd1;
                end else begin
                    w_pos_nxt = 4'd0;
                end
            end
            ST_EXPLODE, ST_FLASH, ST_ENDSCR: begin
                if (restart) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_pos_nxt   = 4'd0;
                end else if (r_pos == POS_LAST) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_pos_nxt   = r_pos + 4'd1;
                    w_state_nxt = state_of(r_pos + 4'd1);
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_pos_nxt   = 4'd0;
            end
        endcase
    end

    // State register; strobe and status flags are registered alongside position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_pos    <= 4'd0;
            r_strobe <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_pos    <= w_pos_nxt;
            r_strobe <= (w_pos_nxt != r_pos);
            r_busy   <= (w_pos_nxt != 4'd0) && (w_pos_nxt != POS_LAST);
            r_done   <= (w_pos_nxt == POS_LAST);
        end
    end

    assign position     = r_pos;
    assign frame_strobe = r_strobe;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_explode_sequencer.sv
// Self-checking bench for explode_sequencer: vector table, directed corner sequences
// and randomized traffic against a position/age reference model.
module tb_explode_sequencer;

    localparam int FT = 4;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       collide = 1'b0;
    logic       restart = 1'b0;
    logic [3:0] position;
    logic       frame_strobe;
    logic       busy;
    logic       done;

    int n_cmp    = 0;
    int n_err    = 0;
    int m_pos    = 0;
    int m_age    = 0;
    int m_strobe = 0;
    int prev_pos = 0;

    typedef struct {
        bit c;
        bit r;
        int pos;
        int stb;
        int bsy;
        int dn;
    } vec_t;

    vec_t tbl[11];

    explode_sequencer #(.FRAME_TICKS(FT)) dut (
        .clk          (clk),
        .reset        (reset),
        .collide      (collide),
        .restart      (restart),
        .position     (position),
        .frame_strobe (frame_strobe),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the reference model on the edge, then compare the DUT.
    task automatic step();
        int np;
        @(posedge clk);
        np = m_pos;
        if (restart) begin
            np    = 0;
            m_age = 0;
        end else if (m_pos == 0) begin
            if (collide) begin
                np    = 1;
                m_age = 0;
            end
        end else if (m_pos < 15) begin
            m_age++;
            if (m_age == FT) begin
                np    = m_pos + 1;
                m_age = 0;
            end
        end
        m_strobe = (np != m_pos) ? 1 : 0;
        m_pos    = np;
        #1;
        chk("position", int'(position), m_pos);
        chk("frame_strobe", int'(frame_strobe), m_strobe);
        chk("busy", int'(busy), (m_pos >= 1 && m_pos <= 14) ? 1 : 0);
        chk("done", int'(done), (m_pos == 15) ? 1 : 0);
        chk("busy_done_exclusive", int'(busy & done), 0);
        chk("monotonic", (int'(position) >= prev_pos || position == 4'd0) ? 1 : 0, 1);
        prev_pos = int'(position);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("reset_position", int'(position), 0);
        chk("reset_strobe", int'(frame_strobe), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        m_pos    = 0;
        m_age    = 0;
        prev_pos = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int strobes;

        tbl[0]  = '{1'b0, 1'b0, 0, 0, 0, 0};
        tbl[1]  = '{1'b0, 1'b0, 0, 0, 0, 0};
        tbl[2]  = '{1'b1, 1'b1, 0, 0, 0, 0};
        tbl[3]  = '{1'b1, 1'b0, 1, 1, 1, 0};
        tbl[4]  = '{1'b0, 1'b0, 1, 0, 1, 0};
        tbl[5]  = '{1'b1, 1'b0, 1, 0, 1, 0};
        tbl[6]  = '{1'b0, 1'b0, 1, 0, 1, 0};
        tbl[7]  = '{1'b0, 1'b0, 2, 1, 1, 0};
        tbl[8]  = '{1'b0, 1'b1, 0, 1, 0, 0};
        tbl[9]  = '{1'b1, 1'b0, 1, 1, 1, 0};
        tbl[10] = '{1'b0, 1'b1, 0, 1, 0, 0};

        #2;
        do_reset();

        for (int i = 0; i < 11; i++) begin
            collide = tbl[i].c;
            restart = tbl[i].r;
            step();
            chk($sformatf("tbl%0d_pos", i), int'(position), tbl[i].pos);
            chk($sformatf("tbl%0d_strobe", i), int'(frame_strobe), tbl[i].stb);
            chk($sformatf("tbl%0d_busy", i), int'(busy), tbl[i].bsy);
            chk($sformatf("tbl%0d_done", i), int'(done), tbl[i].dn);
        end
        restart = 1'b0;
        collide = 1'b0;

        // Full run: single-cycle collide to the END screen.
        collide = 1'b1;
        step();
        collide = 1'b0;
        n       = 1;
        strobes = int'(frame_strobe);
        while (position != 4'd15 && n < 200) begin
            step();
            n++;
            strobes += int'(frame_strobe);
        end
        chk("seqA_cycles_to_15", n, 1 + 14 * FT);
        chk("seqA_strobes", strobes, 15);
        chk("seqA_done", int'(done), 1);
        chk("seqA_busy", int'(busy), 0);

        // Hold at END with collide toggling.
        strobes = 0;
        for (int i = 0; i < 100; i++) begin
            collide = 1'($urandom_range(0, 1));
            step();
            strobes += int'(frame_strobe);
        end
        collide = 1'b0;
        chk("seqB_strobes", strobes, 0);
        chk("seqB_pos", int'(position), 15);
        chk("seqB_done", int'(done), 1);

        // Restart at position 3 / counter 2 with collide held high.
        restart = 1'b1;
        step();
        restart = 1'b0;
        collide = 1'b1;
        step();
        repeat (10) step();
        chk("seqC_pos_before_restart", int'(position), 3);
        restart = 1'b1;
        step();
        chk("seqC_pos_after_restart", int'(position), 0);
        chk("seqC_strobe_after_restart", int'(frame_strobe), 1);
        chk("seqC_busy_after_restart", int'(busy), 0);
        restart = 1'b0;
        step();
        chk("seqC_retrigger_pos", int'(position), 1);
        collide = 1'b0;

        // collide and restart together in IDLE.
        restart = 1'b1;
        step();
        collide = 1'b1;
        strobes = 0;
        repeat (5) begin
            step();
            strobes += int'(frame_strobe);
        end
        chk("seqD_pos", int'(position), 0);
        chk("seqD_strobes", strobes, 0);
        collide = 1'b0;
        restart = 1'b0;

        // Async reset at position 5, then IDLE held with collide low.
        collide = 1'b1;
        step();
        collide = 1'b0;
        repeat (16) step();
        chk("seqE_pos_before_reset", int'(position), 5);
        #2;
        do_reset();
        repeat (10) step();
        chk("seqE_idle_after_release", int'(position), 0);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            collide = ($urandom_range(0, 3) == 0);
            restart = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 699) == 0) begin
                do_reset();
            end else begin
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/explode_sequencer.md
EXPLODE_SEQUENCER -- requirements
Module: explode_sequencer

Interface
REQ-001 Parameter FRAME_TICKS, default 25000000, clock cycles each animation position is held (legal range 2 to 2^26-1).
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 collide  input  1  level, synchronous to clk; ship/asteroid collision detected.
REQ-005 restart  input  1  level, synchronous to clk; player request to leave game-over.
REQ-006 position  output  4  animation index driven to the end-screen pixel generator; 0 = blank, 1-4 = explosion, 5 = full red, 6-15 = END text.
REQ-007 frame_strobe  output  1  one-cycle pulse on every cycle in which position changes value.
REQ-008 busy  output  1  high while the animation is advancing (position 1-14).
REQ-009 done  output  1  high while position = 15 (END screen held).

Function
REQ-010 The block SHALL implement states IDLE, EXPLODE, FLASH, ENDSCR and hold a frame counter of width ceil(log2(FRAME_TICKS)).
REQ-011 IDLE: position = 0; frame counter held at 0; collide = 1 and restart = 0 on a rising edge SHALL move to EXPLODE with position = 1 and counter = 0 on the following cycle.
REQ-012 In EXPLODE, FLASH and ENDSCR the counter SHALL increment each cycle; when counter = FRAME_TICKS-1 and position < 15, counter SHALL return to 0 and position SHALL increment by 1 on the same edge.
REQ-013 Each position 1-14 SHALL therefore be held exactly FRAME_TICKS cycles; collide = 1 to position = 15 SHALL take 1 + 14*FRAME_TICKS cycles.
REQ-014 State SHALL be EXPLODE for positions 1-4, FLASH for position 5 and ENDSCR for positions 6-15, transitions coinciding with the position increments 4->5 and 5->6.
REQ-015 At position = 15 the counter SHALL stop at 0 and position SHALL hold at 15 with no wrap to 0.
REQ-016 restart = 1 in any state other than IDLE SHALL force IDLE with position = 0 and counter = 0 on the next edge, overriding any pending increment.
REQ-017 restart = 1 in IDLE SHALL keep IDLE even if collide = 1 on the same cycle (restart wins).
REQ-018 collide SHALL be ignored outside IDLE; collide held high across a restart SHALL retrigger EXPLODE on the first IDLE cycle with restart = 0.
REQ-019 frame_strobe SHALL be registered and high in exactly the cycle after each edge that changed position, including 0->1 and any restart-forced change to 0; it SHALL NOT pulse while position holds.
REQ-020 busy SHALL be 1 exactly when 1 <= position <= 14; done SHALL be 1 exactly when position = 15; both decoded from registered position, never both high.

Reset
REQ-021 reset = 1 SHALL immediately, without a clock edge, force IDLE, position = 0, counter = 0, frame_strobe = 0, busy = 0, done = 0.
REQ-022 Reset asserted mid-animation SHALL abort it; after release the block SHALL remain in IDLE until collide is sampled high.
REQ-023 The first rising edge after reset deassertion SHALL be treated as a normal IDLE cycle.

Verification (FRAME_TICKS = 4)
REQ-024 Reset, collide pulsed 1 cycle -> position 1,2,3,...,15 each held 4 cycles, 15 reached 57 cycles after the sampling edge, 15 frame_strobe pulses, done = 1 thereafter, busy = 0 at 15.
REQ-025 Hold at position 15 for 100 cycles with collide toggling -> position stays 15, no frame_strobe, done stays 1.
REQ-026 restart at position 3, counter = 2 -> position = 0 next cycle, one frame_strobe, busy = 0; collide held high -> position = 1 one cycle after restart drops.
REQ-027 collide = 1 and restart = 1 together in IDLE -> position remains 0, no frame_strobe.
REQ-028 Asynchronous reset asserted between clock edges at position 5 -> position = 0, busy = 0, frame_strobe = 0 before the next edge; IDLE held after release with collide = 0.
REQ-029 Checker over all runs: position never decreases except to 0 on restart or reset; busy and done never both 1.
